// File: rtl/lsq_ring.sv
// lsq_ring: in-order load/store queue (circular buffer) between dispatch, AGU, ROB commit,
// CDB and a single data-memory port.
//
// Entries are allocated at the tail in program order and issued only from the head.
// A load issues as soon as its address is known. A store issues only after the ROB has
// committed it. The memory port carries one request at a time. A flush drops every
// uncommitted entry and keeps the committed stores at the head.
//
// Ports:
//   clk, rst                     clock (rising edge), asynchronous active-low reset
//   enq_valid/enq_ready          dispatch handshake; enq_ready = !full
//   enq_rob_tag/is_store/funct3  entry descriptor
//   agu_valid/rob_tag/addr/data  address and store-data broadcast
//   commit_valid/commit_rob_tag  ROB commit; only stores record it
//   flush                        misprediction; drop all uncommitted entries
//   cdb_valid/rob_tag/result     load writeback; one-cycle pulse
//   mem_req/we/addr/wdata/wmask  memory request; held until mem_ready
//   mem_ready/mem_rdata          memory completion pulse and read word
//   count, empty                 occupancy
module lsq_ring #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ROB_WIDTH  = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enq_valid,
    output logic                    enq_ready,
    input  logic [ROB_WIDTH-1:0]    enq_rob_tag,
    input  logic                    enq_is_store,
    input  logic [2:0]              enq_funct3,
    input  logic                    agu_valid,
    input  logic [ROB_WIDTH-1:0]    agu_rob_tag,
    input  logic [DATA_WIDTH-1:0]   agu_addr,
    input  logic [DATA_WIDTH-1:0]   agu_data,
    input  logic                    commit_valid,
    input  logic [ROB_WIDTH-1:0]    commit_rob_tag,
    input  logic                    flush,
    output logic                    cdb_valid,
    output logic [ROB_WIDTH-1:0]    cdb_rob_tag,
    output logic [DATA_WIDTH-1:0]   cdb_result,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [DATA_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [3:0]              mem_wmask,
    input  logic                    mem_ready,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {StIdle, StLoad, StStore, StDrop} state_t;

    // Entry storage
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [DEPTH-1:0]      rdy_q, rdy_d;
    logic [DEPTH-1:0]      cmt_q, cmt_d;
    logic [DEPTH-1:0]      store_q, store_d;
    logic [2:0]            f3_q [DEPTH];
    logic [2:0]            f3_d [DEPTH];
    logic [ROB_WIDTH-1:0]  tag_q [DEPTH];
    logic [ROB_WIDTH-1:0]  tag_d [DEPTH];
    logic [DATA_WIDTH-1:0] addr_q [DEPTH];
    logic [DATA_WIDTH-1:0] addr_d [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_d [DEPTH];

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    state_t state_q;

    // Flush bookkeeping: the committed-store run that starts at the head survives
    logic [DEPTH-1:0] keep;
    logic [CNT_W-1:0] n_keep;
    logic             run;
    logic [PTR_W-1:0] idx;

    logic enq_fire, deq_load, deq_store, deq, agu_hit_new, issue_ok;

    assign enq_ready = (count_q != CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;

    assign enq_fire  = enq_valid && enq_ready && !flush;
    // A load that is flushed in the cycle its data returns is discarded
    assign deq_load  = (state_q == StLoad) && mem_ready && !flush;
    assign deq_store = (state_q == StStore) && mem_ready;
    assign deq       = deq_load || deq_store;

    assign agu_hit_new = agu_valid && (agu_rob_tag != '0) && (agu_rob_tag == enq_rob_tag);

    assign issue_ok = valid_q[head_q] && rdy_q[head_q] &&
                      (!store_q[head_q] || cmt_q[head_q]);

    function automatic logic [3:0] store_mask(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'b00:   store_mask = 4'b0001 << off;
            2'b01:   store_mask = 4'b0011 << {off[1], 1'b0};
            default: store_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] store_data(input logic [1:0] sz,
                                                         input logic [DATA_WIDTH-1:0] d);
        case (sz)
            2'b00:   store_data = {(DATA_WIDTH/8){d[7:0]}};
            2'b01:   store_data = {(DATA_WIDTH/16){d[15:0]}};
            default: store_data = d;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] load_ext(input logic [2:0] f3,
                                                       input logic [1:0] off,
                                                       input logic [DATA_WIDTH-1:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = w[{off[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  load_ext = {{(DATA_WIDTH-8){b[7]}}, b};
            3'b001:  load_ext = {{(DATA_WIDTH-16){h[15]}}, h};
            3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, b};
            3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, h};
            default: load_ext = w;
        endcase
    endfunction

    // Entry and pointer next-state
    always_comb begin
        valid_d = valid_q;
        rdy_d   = rdy_q;
        cmt_d   = cmt_q;
        store_d = store_q;
        f3_d    = f3_q;
        tag_d   = tag_q;
        addr_d  = addr_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        keep    = '0;
        n_keep  = '0;
        run     = 1'b1;
        idx     = '0;

        // Commit goes first so a same-cycle flush sees it
        for (int i = 0; i < DEPTH; i++) begin
            if (commit_valid && (commit_rob_tag != '0) && valid_q[i] && store_q[i] &&
                (tag_q[i] == commit_rob_tag)) begin
                cmt_d[i] = 1'b1;
            end
        end

        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PTR_W'(k);
            if (run && valid_q[idx] && store_q[idx] && cmt_d[idx]) begin
                keep[idx] = 1'b1;
                n_keep    = n_keep + CNT_W'(1);
            end else begin
                run = 1'b0;
            end
        end

        if (flush) begin
            valid_d = valid_q & keep;
            tail_d  = head_q + n_keep[PTR_W-1:0];
            count_d = n_keep - CNT_W'(deq);
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (agu_valid && (agu_rob_tag != '0) && valid_q[i] &&
                    (tag_q[i] == agu_rob_tag)) begin
                    rdy_d[i]  = 1'b1;
                    addr_d[i] = agu_addr;
                    data_d[i] = agu_data;
                end
            end
            if (enq_fire) begin
                valid_d[tail_q] = 1'b1;
                rdy_d[tail_q]   = agu_hit_new;
                cmt_d[tail_q]   = 1'b0;
                store_d[tail_q] = enq_is_store;
                f3_d[tail_q]    = enq_funct3;
                tag_d[tail_q]   = enq_rob_tag;
                if (agu_hit_new) begin
                    addr_d[tail_q] = agu_addr;
                    data_d[tail_q] = agu_data;
                end
                tail_d = tail_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(enq_fire) - CNT_W'(deq);
        end

        if (deq) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            rdy_q   <= '0;
            cmt_q   <= '0;
            store_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                f3_q[i]   <= '0;
                tag_q[i]  <= '0;
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            rdy_q   <= rdy_d;
            cmt_q   <= cmt_d;
            store_q <= store_d;
            f3_q    <= f3_d;
            tag_q   <= tag_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Issue FSM with registered memory-port and CDB outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_wmask   <= '0;
            cdb_valid   <= 1'b0;
            cdb_rob_tag <= '0;
            cdb_result  <= '0;
        end else begin
            cdb_valid   <= deq_load;
            cdb_rob_tag <= deq_load ? tag_q[head_q] : '0;
            cdb_result  <= deq_load ?
                           load_ext(f3_q[head_q], addr_q[head_q][1:0], mem_rdata) : '0;
            unique case (state_q)
                StIdle: begin
                    // No issue in a flush cycle: the head may be an entry being dropped
                    if (!flush && issue_ok) begin
                        state_q  <= store_q[head_q] ? StStore : StLoad;
                        mem_req  <= 1'b1;
                        mem_we   <= store_q[head_q];
                        mem_addr <= {addr_q[head_q][DATA_WIDTH-1:2], 2'b00};
                        if (store_q[head_q]) begin
                            mem_wdata <= store_data(f3_q[head_q][1:0], data_q[head_q]);
                            mem_wmask <= store_mask(f3_q[head_q][1:0], addr_q[head_q][1:0]);
                        end
                    end
                end
                StLoad, StStore, StDrop: begin
                    if (mem_ready) begin
                        state_q   <= StIdle;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        mem_wmask <= '0;
                    end else if (flush && (state_q == StLoad)) begin
                        state_q <= StDrop;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/lsq_ring.md
Name: lsq_ring

Overview:
- Parametrised in-order load/store queue between the dispatch stage, AGU/RS broadcast, ROB commit, CDB and the data-memory port.
- Entries are allocated in program order and issued strictly from the head.
- Loads may issue speculatively once their address is known. Stores issue only after ROB commit.
- Adds the following: backpressure, byte/half/word store strobes, LBU/LHU, and misprediction flush that keeps committed stores.

Parameters:
DEPTH, 16, entry count; power of two, >=2
ROB_WIDTH, 4, ROB tag width; tag 0 reserved as "none"
DATA_WIDTH, 32, data and address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
enq_valid  in  1  dispatch presents an entry
enq_ready  out  1  equals !full
enq_rob_tag  in  ROB_WIDTH  tag of the entry
enq_is_store  in  1  1=store, 0=load
enq_funct3  in  3  RV32 funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
agu_valid  in  1  address/data broadcast valid
agu_rob_tag  in  ROB_WIDTH  target entry tag
agu_addr  in  DATA_WIDTH  effective byte address
agu_data  in  DATA_WIDTH  store data (ignored for loads)
commit_valid  in  1  ROB commits a tag
commit_rob_tag  in  ROB_WIDTH  committed tag
flush  in  1  misprediction; drop all uncommitted entries
cdb_valid  out  1  load result valid (1-cycle pulse)
cdb_rob_tag  out  ROB_WIDTH  load tag
cdb_result  out  DATA_WIDTH  extended load data
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  1=write
mem_addr  out  DATA_WIDTH  word-aligned address {addr[31:2],2'b00}
mem_wdata  out  DATA_WIDTH  lane-shifted store data
mem_wmask  out  4  byte strobes
mem_ready  in  1  1-cycle completion pulse
mem_rdata  in  DATA_WIDTH  read word, valid with mem_ready
count  out  log2(DEPTH)+1  occupied entries
empty  out  1  count==0

Behaviour:
- Reset (rst=0, async) clears the following: head=tail=0, count=0, all valid/addr_ready/committed bits=0, FSM=IDLE. All outputs 0 except enq_ready=1 and empty=1.
- Enqueue: fires when enq_valid && enq_ready. Entry written at tail with addr_ready=0 and committed=0; tail wraps modulo DEPTH. enq_ready is derived from registered count only; there is no same-cycle dequeue bypass.
- AGU broadcast: every valid entry whose tag matches captures addr/data and sets addr_ready. A broadcast in the same cycle as an enqueue with the same tag is captured into the new entry.
- Commit: a tag match sets committed. Commits arrive in order, so committed entries are contiguous from head.
- FSM states: IDLE, LOAD, STORE, DROP.
- IDLE: if the head entry is valid and addr_ready, and it is either a load or a committed store, the block asserts mem_req next cycle and enters LOAD or STORE.
- mem_req, mem_we, mem_addr, mem_wdata and mem_wmask stay stable until the cycle mem_ready=1. They deassert the following cycle.
- Store lanes: SB gives mask 0001<<addr[1:0] and data byte replicated to that lane. SH gives mask 0011<<{addr[1],0}. SW gives mask 1111. addr[0] is ignored for SH; addr[1:0] are ignored for SW.
- Loads: select lane by addr[1:0] (halfword by addr[1]). LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word.
- Completion on mem_ready: head dequeues and the FSM returns to IDLE. A load drives cdb_valid=1 with tag and result on the next cycle; a store drives nothing on the CDB. A new issue may start the cycle after return to IDLE, giving at most 1 request per 2 cycles.
- Flush: takes priority over a same-cycle enqueue (not accepted) and AGU broadcast (ignored). A same-cycle commit is applied first.
  - After flush, tail = head + number of committed entries, and count is updated to match.
  - An in-flight STORE continues.
  - An in-flight LOAD moves to DROP: the block waits for mem_ready, discards the data (no cdb_valid) and returns to IDLE.
  - Flush while IDLE with an empty queue is a no-op.
- A load's commit has no effect; loads dequeue on completion.
- Full: count==DEPTH gives enq_ready=0. Enqueue and dequeue in the same cycle leave count unchanged.
- Tags reused after dequeue are legal; only valid entries match.

Test Plan:
- Reset mid-LOAD (mem_req=1, rst pulsed low, no clock edge) -> outputs 0 immediately; enq_ready=1, empty=1.
- LB with addr 0x1003, rdata 0x80FF_0011 -> cdb_result 0xFFFF_FF80 with the enqueued tag; LBU gives 0x0000_0080; LH at 0x1002 gives 0xFFFF_80FF.
- SB at 0x2001, data 0xAB, committed -> mem_we=1, mem_addr 0x2000, mem_wmask 0010, mem_wdata[15:8]=0xAB. Before commit no mem_req occurs.
- Fill DEPTH=16 entries -> enq_ready=0, count=16. Retire one -> enq_ready=1 and tail wraps to index 0.
- Queue: committed SW, uncommitted LW, SW. Flush while the SW is in flight -> store completes, count=0, no CDB output.
- Flush during in-flight LW -> DROP state; mem_ready 3 cycles later produces no cdb_valid, then FSM=IDLE.
